conv1_column_feeder: RTL and testbench

CONV1_COLUMN_FEEDER -- requirements
Module: conv1_column_feeder

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/conv1_column_feeder.sv | 141 ++++++++++++++
 tb/tb_conv1_column_feeder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN definitions: fp16 word type, layer-1 column geometry and the
// column-feeder state encoding.
package cnn_pkg;

    localparam int FP16_WIDTH = 16;
    typedef logic [FP16_WIDTH-1:0] fp16_t;

    // Layer-1 input geometry: 12 rows per column, 4 channels, 12 columns per frame.
    localparam int L1_COL_SIZE = 12;
    localparam int L1_CHANNELS = 4;
    localparam int L1_NUM_COLS = 12;

    typedef enum logic {
        FEED_FILL = 1'b0,
        FEED_HOLD = 1'b1
    } feed_state_t;

    // Bits needed to index 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv1_column_feeder.sv
// Gathers one row-pixel per handshake into a full column and presents it to the conv-1 layer.
// Optional debug outputs (column index, frame count) are enabled by defining CONV1_FEEDER_DBG_EN.
module conv1_column_feeder
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = $bits(fp16_t),
    parameter int COL_SIZE   = L1_COL_SIZE,
    parameter int CHANNELS   = L1_CHANNELS,
    parameter int NUM_COLS   = L1_NUM_COLS,
    parameter int MIN_GAP    = 0
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           pix_valid,
    output logic                                           pix_ready,
    input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]            pix_data,
    input  logic                                           pix_last,
    output logic [CHANNELS-1:0][COL_SIZE-1:0][DATA_WIDTH-1:0] col_out,
    output logic                                           col_valid,
    output logic                                           frame_last,
    output logic                                           err_frame
`ifdef CONV1_FEEDER_DBG_EN
    ,
    output logic [width_of(NUM_COLS)-1:0]                  dbg_col_idx,
    output logic [15:0]                                    dbg_frame_cnt
`endif
);

    localparam int RW = width_of(COL_SIZE);
    localparam int CW = width_of(NUM_COLS);
    localparam int GW = width_of(MIN_GAP + 1);

    localparam logic [RW-1:0] LAST_ROW = RW'(COL_SIZE - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP);

    typedef logic [CHANNELS-1:0][COL_SIZE-1:0][DATA_WIDTH-1:0] column_t;

    feed_state_t   state;
    feed_state_t   state_next;
    logic [RW-1:0] row_cnt;
    logic [RW-1:0] row_next;
    logic [CW-1:0] col_cnt;
    logic [CW-1:0] col_next;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_next;

    column_t wbuf;
    column_t col_asm;

    logic accept;
    logic at_frame_end;
    logic bad_last;
    logic emit;
    logic missing_last;

    assign pix_ready    = (state == FEED_FILL);
    assign accept       = pix_valid & pix_ready;
    assign at_frame_end = (row_cnt == LAST_ROW) && (col_cnt == LAST_COL);

    // A pix_last anywhere but the frame's final pixel aborts the column in flight.
    assign bad_last     = accept & pix_last & ~at_frame_end;
    assign emit         = accept & (row_cnt == LAST_ROW) & ~bad_last;
    assign missing_last = emit & at_frame_end & ~pix_last;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        row_next = row_cnt;
        col_next = col_cnt;
        gap_next = (gap_cnt != '0) ? gap_cnt - GW'(1) : gap_cnt;

        if (bad_last) begin
            row_next = '0;
            col_next = '0;
        end else if (emit) begin
            row_next = '0;
            col_next = (col_cnt == LAST_COL) ? '0 : col_cnt + CW'(1);
            gap_next = GAP_LOAD;
        end else if (accept) begin
            row_next = row_cnt + RW'(1);
        end

        // State tracks the registered stall condition exactly, so pix_ready is glitch-free.
        state_next = ((row_next == LAST_ROW) && (gap_next != '0)) ? FEED_HOLD : FEED_FILL;
    end

    // The final row goes straight from pix_data into the emitted column.
    always_comb begin
        col_asm = wbuf;
        for (int c = 0; c < CHANNELS; c++) begin
            col_asm[c][COL_SIZE-1] = pix_data[c];
        end
    end

    // NOTE: the write buffer carries no reset; every row is rewritten before it is emitted.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wbuf[c][row_cnt] <= pix_data[c];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FEED_FILL;
            row_cnt    <= '0;
            col_cnt    <= '0;
            gap_cnt    <= '0;
            col_out    <= '0;
            col_valid  <= 1'b0;
            frame_last <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            state      <= state_next;
            row_cnt    <= row_next;
            col_cnt    <= col_next;
            gap_cnt    <= gap_next;
            col_valid  <= emit;
            frame_last <= emit & (col_cnt == LAST_COL);
            err_frame  <= err_frame | bad_last | missing_last;
            if (emit) begin
                col_out <= col_asm;
            end
        end
    end

`ifdef CONV1_FEEDER_DBG_EN
    assign dbg_col_idx = col_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_frame_cnt <= '0;
        end else if (emit && (col_cnt == LAST_COL)) begin
            dbg_frame_cnt <= dbg_frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv1_column_feeder.sv
// Self-checking bench for conv1_column_feeder: table-driven stream cases plus
// hand-written gap, pix_last-error and mid-column reset sequences, scoreboarded.
`timescale 1ns/1ps
module tb_conv1_column_feeder;
    import cnn_pkg::*;

    localparam int DW   = 16;
    localparam int CS   = 12;
    localparam int CH   = 4;
    localparam int NC   = 12;
    localparam int COLW = DW * CS * CH;

    typedef logic [CH-1:0][CS-1:0][DW-1:0] col_t;
    typedef logic [CH-1:0][DW-1:0]         pix_t;

    typedef struct {
        col_t data;
        logic last;
    } exp_t;

    typedef struct {
        int   n_cols;
        bit   bubbles;
        bit   give_last;
        logic exp_err;
        int   exp_frames;
    } case_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic pix_valid = 1'b0;
    logic pix_last = 1'b0;
    pix_t pix_data = '0;

    logic v0, v1, rdy0, rdy1, cv0, cv1, fl0, fl1, ef0, ef1;
    col_t co0, co1;
    logic m_ready, m_col_valid, m_frame_last, m_err;
    col_t m_col_out;

    assign v0           = pix_valid & ~sel;
    assign v1           = pix_valid & sel;
    assign m_ready      = sel ? rdy1 : rdy0;
    assign m_col_valid  = sel ? cv1  : cv0;
    assign m_frame_last = sel ? fl1  : fl0;
    assign m_err        = sel ? ef1  : ef0;
    assign m_col_out    = sel ? co1  : co0;

`ifdef CONV1_FEEDER_DBG_EN
    logic [3:0]  dbg_idx0, dbg_idx1;
    logic [15:0] dbg_fc0, dbg_fc1;
`endif

    conv1_column_feeder #(.MIN_GAP(0)) dut0 (
        .clk(clk), .rst(rst), .pix_valid(v0), .pix_ready(rdy0), .pix_data(pix_data),
        .pix_last(pix_last), .col_out(co0), .col_valid(cv0), .frame_last(fl0), .err_frame(ef0)
`ifdef CONV1_FEEDER_DBG_EN
        , .dbg_col_idx(dbg_idx0), .dbg_frame_cnt(dbg_fc0)
`endif
    );

    conv1_column_feeder #(.MIN_GAP(20)) dut20 (
        .clk(clk), .rst(rst), .pix_valid(v1), .pix_ready(rdy1), .pix_data(pix_data),
        .pix_last(pix_last), .col_out(co1), .col_valid(cv1), .frame_last(fl1), .err_frame(ef1)
`ifdef CONV1_FEEDER_DBG_EN
        , .dbg_col_idx(dbg_idx1), .dbg_frame_cnt(dbg_fc1)
`endif
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t expq[$];
    int   cyc = 0;
    int   last_pulse = -1;
    int   exp_spacing = 0;
    int   frames_seen = 0;
    int   pulses_seen = 0;
    int   stall_cnt = 0;
    int   kpix = 0;
    int   model_row = 0;
    int   model_col = 0;
    col_t wbuf_m = '0;

    task automatic check(input string name, input logic [COLW-1:0] act, input logic [COLW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_frame_last) check_int("frame_last_with_col_valid", int'(m_col_valid), 1);
            if (m_col_valid) begin
                pulses_seen++;
                if (expq.size() == 0) begin
                    check_int("col_valid_unexpected", int'(m_col_valid), 0);
                end else begin
                    e = expq.pop_front();
                    check("col_out", m_col_out, e.data);
                    check_int("frame_last", int'(m_frame_last), int'(e.last));
                    if (exp_spacing != 0 && last_pulse >= 0)
                        check_int("pulse_spacing", cyc - last_pulse, exp_spacing);
                end
                if (m_frame_last) frames_seen++;
                last_pulse = cyc;
            end
        end
    endtask

    task automatic clear_model();
        expq.delete();
        model_row   = 0;
        model_col   = 0;
        last_pulse  = -1;
        frames_seen = 0;
        pulses_seen = 0;
        stall_cnt   = 0;
    endtask

    task automatic do_reset();
        pix_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
    endtask

    // Offers one pixel (optionally after a random idle cycle) and updates the model on handshake.
    task automatic send_pixel(input bit bubbles, input logic last);
        pix_t d;
        bit   done;
        exp_t e;
        if (bubbles && $urandom_range(1, 0) == 1) begin
            pix_valid = 1'b0;
            pix_data  = {$urandom(), $urandom()};
            pix_last  = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < CH; c++) d[c] = DW'(kpix * CH + c);
        kpix++;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = last;
        done = 1'b0;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            if (m_ready) done = 1'b1;
            else stall_cnt++;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            check_int("handshake_timeout", 0, 1);
            return;
        end
        for (int c = 0; c < CH; c++) wbuf_m[c][model_row] = d[c];
        if (last && !(model_row == CS - 1 && model_col == NC - 1)) begin
            model_row = 0;
            model_col = 0;
        end else if (model_row == CS - 1) begin
            e.data = wbuf_m;
            e.last = (model_col == NC - 1);
            expq.push_back(e);
            model_row = 0;
            model_col = (model_col == NC - 1) ? 0 : model_col + 1;
        end else begin
            model_row++;
        end
    endtask

    task automatic send_column(input bit bubbles, input bit give_last);
        for (int r = 0; r < CS; r++)
            send_pixel(bubbles, give_last && r == CS - 1 && model_col == NC - 1);
    endtask

    task automatic drain();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        for (int t = 0; t < 200 && expq.size() != 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check_int("queue_drained", expq.size(), 0);
    endtask

    case_t cases[5];

    initial begin
        cases[0] = '{n_cols: 12, bubbles: 1'b0, give_last: 1'b1, exp_err: 1'b0, exp_frames: 1};
        cases[1] = '{n_cols: 12, bubbles: 1'b1, give_last: 1'b1, exp_err: 1'b0, exp_frames: 1};
        cases[2] = '{n_cols: 12, bubbles: 1'b0, give_last: 1'b0, exp_err: 1'b1, exp_frames: 1};
        cases[3] = '{n_cols: 24, bubbles: 1'b1, give_last: 1'b1, exp_err: 1'b0, exp_frames: 2};
        cases[4] = '{n_cols: 5,  bubbles: 1'b0, give_last: 1'b1, exp_err: 1'b0, exp_frames: 0};

        fork
            monitor();
        join_none

        // Reset state, both instances.
        #3;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check("rst_col_out", m_col_out, '0);
            check_int("rst_col_valid", int'(m_col_valid), 0);
            check_int("rst_frame_last", int'(m_frame_last), 0);
            check_int("rst_err_frame", int'(m_err), 0);
            check_int("rst_pix_ready", int'(m_ready), 1);
        end
        sel = 1'b0;

        // Table-driven stream cases on the MIN_GAP=0 instance.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            check_int("ready_after_reset", int'(m_ready), 1);
            exp_spacing = cases[i].bubbles ? 0 : CS;
            for (int n = 0; n < cases[i].n_cols; n++) send_column(cases[i].bubbles, cases[i].give_last);
            drain();
            check_int("case_pulses", pulses_seen, cases[i].n_cols);
            check_int("case_frames", frames_seen, cases[i].exp_frames);
            check_int("case_err_frame", int'(m_err), int'(cases[i].exp_err));
        end

        // Early pix_last on row 5 of column 3: column dropped, counters restart.
        exp_spacing = 0;
        do_reset();
        for (int n = 0; n < 3; n++) send_column(1'b0, 1'b1);
        for (int r = 0; r < 5; r++) send_pixel(1'b0, 1'b0);
        send_pixel(1'b0, 1'b1);
        drain();
        check_int("early_last_pulses", pulses_seen, 3);
        check_int("early_last_err", int'(m_err), 1);
        for (int n = 0; n < NC; n++) send_column(1'b0, 1'b1);
        drain();
        check_int("after_err_pulses", pulses_seen, 3 + NC);
        check_int("after_err_frames", frames_seen, 1);
        check_int("err_sticky", int'(m_err), 1);

        // MIN_GAP=20 instance: row 11 stalls for 9 cycles, pulses 21 apart.
        sel = 1'b1;
        exp_spacing = 21;
        do_reset();
        for (int n = 0; n < 3; n++) send_column(1'b0, 1'b1);
        drain();
        check_int("gap_pulses", pulses_seen, 3);
        check_int("gap_stalls", stall_cnt, 18);
        sel = 1'b0;

        // Asynchronous reset at row 7 of a column.
        exp_spacing = 0;
        do_reset();
        send_column(1'b0, 1'b1);
        drain();
        for (int r = 0; r < 7; r++) send_pixel(1'b0, 1'b0);
        pix_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_col_out", m_col_out, '0);
        check_int("midrst_col_valid", int'(m_col_valid), 0);
        check_int("midrst_frame_last", int'(m_frame_last), 0);
        check_int("midrst_err", int'(m_err), 0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        send_column(1'b0, 1'b1);
        drain();
        check_int("midrst_pulses", pulses_seen, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
